// File: rtl/hzd_pkg.sv
// Shared types and constants for the hazard/forwarding control unit.
// Optional HZD_PERF_EN performance counters live in hzd_ctrl_unit.
package hzd_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        LSTALL = 2'b01,
        MWAIT  = 2'b10
    } hzd_state_e;

    localparam int REG_ZERO = 0;

    localparam int N_PERF = 3;
    localparam int PERF_STALL = 0;
    localparam int PERF_FLUSH = 1;
    localparam int PERF_MWAIT = 2;

endpackage

// File: rtl/hzd_ctrl_unit_fwd_sel.sv
// Per-operand forwarding selector; EX/MEM result wins over MEM/WB.
// Loads in MEM are not forwarded from EX/MEM (their data is not ready there).
module fwd_sel
    import hzd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    output logic [1:0]        fwd
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write && !exmem_mem_read &&
                       (exmem_rd != REG_AW'(REG_ZERO)) && (exmem_rd == idex_rs);
    assign memwb_hit = memwb_reg_write &&
                       (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == idex_rs);

    always_comb begin
        fwd = FWD_RF;
        if (exmem_hit) begin
            fwd = FWD_EXMEM;
        end else if (memwb_hit) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hzd_ctrl_unit.sv
// Forwarding, load-use stall, data-memory wait freeze and branch flush control.
// Define HZD_PERF_EN to add saturating stall/flush/memory-wait counters.
module hzd_ctrl_unit
    import hzd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_use_rs1,
    input  logic              ifid_use_rs2,
    input  logic [REG_AW-1:0] idex_rs1,
    input  logic [REG_AW-1:0] idex_rs2,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_MemRead,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_RegWrite,
    input  logic              exmem_MemRead,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_RegWrite,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic              PCWrite,
    output logic              ifidWrite,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              pipe_hold
`ifdef HZD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cyc,
    output logic [CNT_W-1:0]  perf_flush_cnt,
    output logic [CNT_W-1:0]  perf_mwait_cyc
`endif
);

    hzd_state_e state_reg, state_next;
    hzd_state_e saved_reg, saved_next;
    hzd_state_e eff_state;
    logic [2:0] cnt_reg, cnt_next;

    logic [1:0] fwd_a, fwd_b;
    logic       mem_wait;
    logic       luh;
    logic       load_stall;
    logic       branch_flush;
    logic       pc_write_c, ifid_write_c, bubble_c, flush_c, hold_c;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .idex_rs         (idex_rs1),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_RegWrite),
        .exmem_mem_read  (exmem_MemRead),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_RegWrite),
        .fwd             (fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .idex_rs         (idex_rs2),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_RegWrite),
        .exmem_mem_read  (exmem_MemRead),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_RegWrite),
        .fwd             (fwd_b)
    );

    assign mem_wait = dmem_req && !dmem_ready;
    assign luh = idex_MemRead && (idex_rd != REG_AW'(REG_ZERO)) &&
                 ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
                  (ifid_use_rs2 && (idex_rd == ifid_rs2)));

    // While frozen, the machine behaves as the state it was in before the wait.
    assign eff_state = (state_reg == MWAIT) ? saved_reg : state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            saved_reg <= RUN;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            saved_reg <= saved_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        saved_next   = saved_reg;
        cnt_next     = cnt_reg;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        bubble_c     = 1'b0;
        flush_c      = 1'b0;
        hold_c       = 1'b0;
        load_stall   = 1'b0;
        branch_flush = 1'b0;

        if (mem_wait) begin
            state_next   = MWAIT;
            saved_next   = eff_state;
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            hold_c       = 1'b1;
        end else if (ex_branch_taken) begin
            // The load-stalled instruction is being flushed, so the stall is moot.
            branch_flush = 1'b1;
            flush_c      = 1'b1;
            bubble_c     = 1'b1;
            state_next   = RUN;
            saved_next   = RUN;
            cnt_next     = 3'd0;
        end else if (eff_state == LSTALL) begin
            load_stall   = 1'b1;
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            bubble_c     = 1'b1;
            if (cnt_reg <= 3'd1) begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end else begin
                state_next = LSTALL;
                cnt_next   = cnt_reg - 3'd1;
            end
        end else begin
            state_next = RUN;
            if (luh) begin
                load_stall   = 1'b1;
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                bubble_c     = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_next = LSTALL;
                    cnt_next   = 3'(LOAD_LAT - 1);
                end
            end
        end
    end

    // Reset forces a safe pipeline: nothing advances and ID/EX is bubbled.
    assign forwardA    = rst_n ? fwd_a : FWD_RF;
    assign forwardB    = rst_n ? fwd_b : FWD_RF;
    assign PCWrite     = rst_n && pc_write_c;
    assign ifidWrite   = rst_n && ifid_write_c;
    assign idex_bubble = !rst_n || bubble_c;
    assign ifid_flush  = rst_n && flush_c;
    assign pipe_hold   = rst_n && hold_c;

    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

`ifdef HZD_PERF_EN
    logic [N_PERF-1:0] perf_inc;

    assign perf_inc[PERF_STALL] = load_stall;
    assign perf_inc[PERF_FLUSH] = branch_flush;
    assign perf_inc[PERF_MWAIT] = hold_c;

    for (genvar gi = 0; gi < N_PERF; gi++) begin : g_perf
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (perf_inc[gi] && !(&cnt_reg)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign perf_stall_cyc = g_perf[PERF_STALL].cnt_reg;
    assign perf_flush_cnt = g_perf[PERF_FLUSH].cnt_reg;
    assign perf_mwait_cyc = g_perf[PERF_MWAIT].cnt_reg;
`endif

endmodule

// File: tb/tb_hzd_ctrl_unit.sv
// Directed and random checks of hzd_ctrl_unit at LOAD_LAT=1 and LOAD_LAT=3.
// Counter checks are compiled in when HZD_PERF_EN is defined.
module tb_hzd_ctrl_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic       ifid_use_rs1, ifid_use_rs2, idex_MemRead;
    logic       exmem_RegWrite, exmem_MemRead, memwb_RegWrite;
    logic       ex_branch_taken, dmem_req, dmem_ready;

    logic [1:0] fa1, fb1, fa3, fb3;
    logic       pcw1, ifw1, bub1, fl1, ph1;
    logic       pcw3, ifw3, bub3, fl3, ph3;
`ifdef HZD_PERF_EN
    logic [7:0] ps1, pf1, pm1, ps3, pf3, pm3;
    int m_ps1, m_ps3, m_pf, m_pm;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int sl1      = 0;   // remaining stall cycles after the current one
    int sl3      = 0;

    hzd_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(8)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_MemRead(idex_MemRead),
        .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite), .exmem_MemRead(exmem_MemRead),
        .memwb_rd(memwb_rd), .memwb_RegWrite(memwb_RegWrite),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .forwardA(fa1), .forwardB(fb1), .PCWrite(pcw1), .ifidWrite(ifw1),
        .idex_bubble(bub1), .ifid_flush(fl1), .pipe_hold(ph1)
`ifdef HZD_PERF_EN
        , .perf_stall_cyc(ps1), .perf_flush_cnt(pf1), .perf_mwait_cyc(pm1)
`endif
    );

    hzd_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(8)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_MemRead(idex_MemRead),
        .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite), .exmem_MemRead(exmem_MemRead),
        .memwb_rd(memwb_rd), .memwb_RegWrite(memwb_RegWrite),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .forwardA(fa3), .forwardB(fb3), .PCWrite(pcw3), .ifidWrite(ifw3),
        .idex_bubble(bub3), .ifid_flush(fl3), .pipe_hold(ph3)
`ifdef HZD_PERF_EN
        , .perf_stall_cyc(ps3), .perf_flush_cnt(pf3), .perf_mwait_cyc(pm3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic luh_m();
        return idex_MemRead && (idex_rd != 5'd0) &&
               ((ifid_use_rs1 && idex_rd == ifid_rs1) || (ifid_use_rs2 && idex_rd == ifid_rs2));
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (!rst_n) return 2'b00;
        if (exmem_RegWrite && !exmem_MemRead && exmem_rd != 5'd0 && exmem_rd == rs) return 2'b10;
        if (memwb_RegWrite && memwb_rd != 5'd0 && memwb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {PCWrite, ifidWrite, idex_bubble, ifid_flush, pipe_hold}
    function automatic logic [4:0] exp_ctrl(input int sl);
        if (!rst_n) return 5'b00100;
        if (dmem_req && !dmem_ready) return 5'b00001;
        if (ex_branch_taken) return 5'b11110;
        if (sl > 0 || luh_m()) return 5'b00100;
        return 5'b11000;
    endfunction

    function automatic int next_sl(input int sl, input int lat);
        if (!rst_n) return 0;
        if (dmem_req && !dmem_ready) return sl;
        if (ex_branch_taken) return 0;
        if (sl > 0) return sl - 1;
        if (luh_m()) return lat - 1;
        return 0;
    endfunction

    function automatic int sat_inc(input int v, input logic en);
        if (!en || v == 255) return v;
        return v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (fail #%0d)", tag, obs, exp, n_fail);
        end
    endtask

    task automatic check_dut(input string tag, input logic [4:0] e,
                             input logic [1:0] fa, input logic [1:0] fb,
                             input logic [4:0] ctrl);
        check({tag, ".forwardA"}, 32'(fa), 32'(exp_fwd(idex_rs1)));
        check({tag, ".forwardB"}, 32'(fb), 32'(exp_fwd(idex_rs2)));
        check({tag, ".PCWrite"}, 32'(ctrl[4]), 32'(e[4]));
        check({tag, ".ifidWrite"}, 32'(ctrl[3]), 32'(e[3]));
        check({tag, ".idex_bubble"}, 32'(ctrl[2]), 32'(e[2]));
        check({tag, ".ifid_flush"}, 32'(ctrl[1]), 32'(e[1]));
        check({tag, ".pipe_hold"}, 32'(ctrl[0]), 32'(e[0]));
    endtask

    // One pipeline cycle: check outputs mid-cycle, then advance model at the edge.
    task automatic step(input string tag);
        logic [4:0] e1, e3;
        @(negedge clk);
        e1 = exp_ctrl(sl1);
        e3 = exp_ctrl(sl3);
        check_dut({tag, "/L1"}, e1, fa1, fb1, {pcw1, ifw1, bub1, fl1, ph1});
        check_dut({tag, "/L3"}, e3, fa3, fb3, {pcw3, ifw3, bub3, fl3, ph3});
`ifdef HZD_PERF_EN
        check({tag, "/L1.perf_stall"}, 32'(ps1), 32'(m_ps1));
        check({tag, "/L3.perf_stall"}, 32'(ps3), 32'(m_ps3));
        check({tag, "/L1.perf_flush"}, 32'(pf1), 32'(m_pf));
        check({tag, "/L3.perf_flush"}, 32'(pf3), 32'(m_pf));
        check({tag, "/L1.perf_mwait"}, 32'(pm1), 32'(m_pm));
        check({tag, "/L3.perf_mwait"}, 32'(pm3), 32'(m_pm));
`endif
        $display("%0t %s fA=%b fB=%b L1:pcw=%b bub=%b fl=%b ph=%b L3:pcw=%b bub=%b fl=%b ph=%b",
                 $time, tag, fa1, fb1, pcw1, bub1, fl1, ph1, pcw3, bub3, fl3, ph3);
        @(posedge clk);
`ifdef HZD_PERF_EN
        if (!rst_n) begin
            m_ps1 = 0; m_ps3 = 0; m_pf = 0; m_pm = 0;
        end else begin
            m_ps1 = sat_inc(m_ps1, e1 == 5'b00100);
            m_ps3 = sat_inc(m_ps3, e3 == 5'b00100);
            m_pf  = sat_inc(m_pf, e1[1]);
            m_pm  = sat_inc(m_pm, e1[0]);
        end
`endif
        sl1 = next_sl(sl1, 1);
        sl3 = next_sl(sl3, 3);
        #1;
    endtask

    task automatic idle();
        ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0;
        idex_rs1 = 5'd0; idex_rs2 = 5'd0; idex_rd = 5'd0; idex_MemRead = 1'b0;
        exmem_rd = 5'd0; exmem_RegWrite = 1'b0; exmem_MemRead = 1'b0;
        memwb_rd = 5'd0; memwb_RegWrite = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic use2);
        idle();
        idex_MemRead = 1'b1; idex_rd = rd;
        ifid_rs1 = use2 ? 5'd1 : rd; ifid_use_rs1 = !use2;
        ifid_rs2 = use2 ? rd : 5'd2; ifid_use_rs2 = use2;
    endtask

    initial begin
`ifdef HZD_PERF_EN
        m_ps1 = 0; m_ps3 = 0; m_pf = 0; m_pm = 0;
`endif
        rst_n = 1'b0;
        idle();
        // Reset with live hazards present: everything must still read as reset values.
        exmem_rd = 5'd5; exmem_RegWrite = 1'b1; idex_rs1 = 5'd5; idex_rs2 = 5'd5;
        load_use(5'd6, 1'b1);
        step("reset");
        rst_n = 1'b1;
        idle();
        step("run_idle");

        // Forwarding priority and x0 exclusion
        idle();
        exmem_rd = 5'd5; exmem_RegWrite = 1'b1; memwb_rd = 5'd5; memwb_RegWrite = 1'b1;
        idex_rs1 = 5'd5; idex_rs2 = 5'd5;
        step("fwd_exmem");
        exmem_rd = 5'd0;
        step("fwd_memwb");
        exmem_rd = 5'd5; exmem_MemRead = 1'b1;
        step("fwd_load_in_mem");
        memwb_rd = 5'd0;
        step("fwd_none");

        // Load-use on rs2 of an R-type, then I-type not using rs2
        load_use(5'd6, 1'b1);
        step("luh_rs2");
        idle();
        for (int i = 0; i < 3; i++) step("after_luh");
        load_use(5'd6, 1'b1); ifid_use_rs2 = 1'b0;
        step("itype_no_stall");

        // Load-use on rs1 (x7), and a load to x0
        load_use(5'd7, 1'b0);
        step("luh_rs1");
        idle();
        for (int i = 0; i < 3; i++) step("after_luh7");
        load_use(5'd0, 1'b0);
        step("load_x0");

        // Branch in the same cycle as load-use
        load_use(5'd8, 1'b0); ex_branch_taken = 1'b1;
        step("luh_branch");
        idle();
        for (int i = 0; i < 3; i++) step("after_branch");

        // Memory wait inside LSTALL
        load_use(5'd9, 1'b1);
        step("luh_pre_wait");
        idle(); dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("mwait");
        dmem_ready = 1'b1;
        step("mwait_ready");
        idle();
        for (int i = 0; i < 3; i++) step("after_mwait");

        // Asynchronous reset mid-LSTALL
        load_use(5'd10, 1'b0);
        step("luh_pre_rst");
        idle();
        step("lstall_pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst/L3.PCWrite", 32'(pcw3), 32'd0);
        check("async_rst/L3.ifidWrite", 32'(ifw3), 32'd0);
        check("async_rst/L3.idex_bubble", 32'(bub3), 32'd1);
        check("async_rst/L3.pipe_hold", 32'(ph3), 32'd0);
        check("async_rst/L3.ifid_flush", 32'(fl3), 32'd0);
        sl1 = 0; sl3 = 0;
`ifdef HZD_PERF_EN
        m_ps1 = 0; m_ps3 = 0; m_pf = 0; m_pm = 0;
`endif
        step("in_reset");
        #2 rst_n = 1'b1;
        step("post_reset");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ifid_rs1 = 5'($urandom_range(0, 7));
            ifid_rs2 = 5'($urandom_range(0, 7));
            ifid_use_rs1 = 1'($urandom_range(0, 1));
            ifid_use_rs2 = 1'($urandom_range(0, 1));
            idex_rs1 = 5'($urandom_range(0, 7));
            idex_rs2 = 5'($urandom_range(0, 7));
            idex_rd  = 5'($urandom_range(0, 7));
            idex_MemRead = ($urandom_range(0, 9) < 4);
            exmem_rd = 5'($urandom_range(0, 7));
            exmem_RegWrite = 1'($urandom_range(0, 1));
            exmem_MemRead = ($urandom_range(0, 9) < 3);
            memwb_rd = 5'($urandom_range(0, 7));
            memwb_RegWrite = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            dmem_req = ($urandom_range(0, 9) < 3);
            dmem_ready = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hzd_ctrl_unit.md
Name: hzd_ctrl_unit

Overview:
Parametrised successor to the 5-stage RV32I forwarding and hazard logic, combining both in one clocked block. It adds the following over the current logic:
- per-operand use flags, so non-R-type instructions are handled correctly;
- multi-cycle load-use stalls;
- a data-memory wait freeze;
- taken-branch flush.

It sits beside the pipeline registers and drives the ALU operand muxes, the PC/IFID write enables, the ID/EX bubble and the flushes.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 1, load-use stall cycles (1..7)
CNT_W, 32, perf-counter width (used only with HZD_PERF_EN)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset; asynchronous, active-low
ifid_rs1, ifid_rs2  in  REG_AW each  source registers of the instruction in ID
ifid_use_rs1, ifid_use_rs2  in  1 each  the ID instruction reads rs1 / rs2
idex_rs1, idex_rs2, idex_rd  in  REG_AW each  register fields in EX
idex_MemRead  in  1  the EX instruction is a load
exmem_rd  in  REG_AW  destination register in MEM
exmem_RegWrite, exmem_MemRead  in  1 each  MEM-stage controls
memwb_rd  in  REG_AW  destination register in WB
memwb_RegWrite  in  1  WB-stage write enable
ex_branch_taken  in  1  branch or jump resolved taken in EX
dmem_req, dmem_ready  in  1 each  data-memory request / ready
forwardA, forwardB  out  2 each  00 = register file, 01 = MEM/WB, 10 = EX/MEM
PCWrite, ifidWrite  out  1 each  write enables
idex_bubble  out  1  active-high; zero the control bits entering ID/EX
ifid_flush  out  1  clear IF/ID
pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB

Behaviour:
Forwarding (combinational), per operand; EX/MEM has priority over MEM/WB:
- Select 10 when exmem_RegWrite && !exmem_MemRead && exmem_rd!=0 && exmem_rd==idex_rsX.
- Else select 01 when memwb_RegWrite && memwb_rd!=0 && memwb_rd==idex_rsX.
- Else select 00.

Load-use detection:
- luh = idex_MemRead && idex_rd!=0 && ((ifid_use_rs1 && idex_rd==ifid_rs1) || (ifid_use_rs2 && idex_rd==ifid_rs2)).
- Register x0 never triggers a hazard.

FSM states: RUN, LSTALL, MWAIT. State register plus a 3-bit counter cnt.

RUN:
- Outputs: PCWrite=1, ifidWrite=1, idex_bubble=0, ifid_flush=0, pipe_hold=0.
- If luh: the same cycle drives PCWrite=0, ifidWrite=0, idex_bubble=1. If LOAD_LAT>1, go to LSTALL with cnt=LOAD_LAT-1; if LOAD_LAT==1, stay in RUN.

LSTALL:
- Outputs: PCWrite=0, ifidWrite=0, idex_bubble=1.
- cnt decrements each cycle; at cnt==1, return to RUN next cycle.
- Total stall cycles = LOAD_LAT.

MWAIT:
- Entered from any state when dmem_req && !dmem_ready.
- Outputs: pipe_hold=1, PCWrite=0, ifidWrite=0, idex_bubble=0.
- Freezes cnt and saves the prior state; returns to it on the first cycle with dmem_ready=1.
- The freeze is combinational in the entering cycle.

Priority when events coincide: memory wait > branch flush > load stall.

Taken branch (not in MWAIT):
- ifid_flush=1, idex_bubble=1, PCWrite=1.
- Cancels any LSTALL (the stalled instruction is flushed): next state RUN, cnt=0.

Reset:
- Asynchronous: state=RUN, cnt=0, saved state=RUN, counters=0.
- While rst_n=0: PCWrite=0, ifidWrite=0, idex_bubble=1, ifid_flush=0, pipe_hold=0, forwardA=forwardB=00.
- Reset asserted mid-stall aborts the stall immediately.

Optional Feature:
HZD_PERF_EN:
- Defined: adds outputs perf_stall_cyc, perf_flush_cnt, perf_mwait_cyc, each CNT_W bits.
  - perf_stall_cyc increments on cycles with idex_bubble=1 caused by a load stall.
  - perf_flush_cnt increments on each taken-branch flush.
  - perf_mwait_cyc increments on each MWAIT cycle.
  - All three saturate at all-ones and clear on reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
Package hzd_pkg holds:
- fwd_sel_e: FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10;
- hzd_state_e: RUN, LSTALL, MWAIT;
- the register-zero constant.

Sub-module fwd_sel: combinational per-operand forward selector, instantiated twice (operand A, operand B).

Test Plan:
- EX/MEM and MEM/WB both write x5, both with RegWrite=1, exmem_MemRead=0; idex_rs1=5 -> forwardA=10. Repeat with exmem_rd=0 -> forwardA=01.
- LOAD_LAT=1: lw x6 in EX with idex_MemRead=1; ID instruction has ifid_rs2=6, ifid_use_rs2=1 -> exactly 1 cycle with PCWrite=0, idex_bubble=1. Repeat with ifid_use_rs2=0 (I-type) -> no stall.
- LOAD_LAT=3: load-use on x7 -> exactly 3 consecutive stall cycles, then RUN. Load with idex_rd=0 -> no stall.
- Load-use stall with ex_branch_taken=1 in the same cycle -> ifid_flush=1, PCWrite=1, next state RUN, no further stall cycles.
- In LSTALL (cnt=2), dmem_req=1 with dmem_ready=0 for 4 cycles -> pipe_hold=1 for 4 cycles, cnt stays 2, LSTALL resumes after ready.
- Assert rst_n=0 asynchronously mid-LSTALL -> outputs take their reset values immediately; after release, RUN with PCWrite=1. With HZD_PERF_EN, counters read 0 after reset.
